// File: rtl/pio_pkg.sv
// Shared definitions for the programmable-I/O execution core: instruction
// layout, opcode/condition/destination codes and the SET field helper.
package pio_pkg;

    localparam int IMEM_DEPTH = 32;
    localparam int INSTR_W    = 16;
    localparam int ADDR_W     = 5;
    localparam int PIN_COUNT  = 32;
    localparam int DELAY_W    = 5;
    localparam int SET_WIDTH  = 5;

    localparam logic [2:0] OP_JMP  = 3'b000;
    localparam logic [2:0] OP_WAIT = 3'b001;
    localparam logic [2:0] OP_SET  = 3'b111;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_PIN    = 3'b110;

    localparam logic [2:0] DEST_PINS    = 3'b000;
    localparam logic [2:0] DEST_PINDIRS = 3'b100;

    typedef struct packed {
        logic [2:0]         opcode;
        logic [DELAY_W-1:0] delay;
        logic [7:0]         args;
    } instr_t;

    // Replace SET_WIDTH consecutive bits starting at base; the pin index wraps modulo 32.
    function automatic logic [PIN_COUNT-1:0] apply_set(
        input logic [PIN_COUNT-1:0] cur,
        input logic [ADDR_W-1:0]    base,
        input logic [SET_WIDTH-1:0] data
    );
        logic [PIN_COUNT-1:0] res;
        logic [ADDR_W-1:0]    idx;
        res = cur;
        for (int k = 0; k < SET_WIDTH; k++) begin
            idx      = base + ADDR_W'(k);
            res[idx] = data[k];
        end
        return res;
    endfunction

endpackage

// File: rtl/pio_exec_unit_chk.sv
// Structural invariants of the execution core's pin outputs.
module pio_exec_unit_chk
    import pio_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    input logic [PIN_COUNT-1:0] core_output,
    input logic [PIN_COUNT-1:0] core_drive
);

    a_reset_clears: assert property (@(posedge clk)
        rst |=> (core_output == 32'h0000_0000) && (core_drive == 32'h0000_0000));

    a_output_only_when_driven: assert property (@(posedge clk)
        (core_output & ~core_drive) == 32'h0000_0000);

endmodule

// File: rtl/pio_sm.sv
// One sequencer: executes the instruction at its pc each enabled cycle and
// keeps its own pin values and output enables. Optional PIO_DELAY_EN adds per-instruction idle cycles.
module pio_sm
    import pio_pkg::*;
#(
    parameter int SET_BASE = 0,
    parameter int JMP_PIN  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [INSTR_W-1:0]   instr,
    input  logic [PIN_COUNT-1:0] gpio_input,
    output logic [ADDR_W-1:0]    pc,
    output logic [PIN_COUNT-1:0] fsm_output,
    output logic [PIN_COUNT-1:0] fsm_drive
);

    localparam logic [ADDR_W-1:0] SET_BASE_L = SET_BASE[ADDR_W-1:0];

    instr_t                 instr_s;
    logic [2:0]             field_hi_s;
    logic [4:0]             field_lo_s;
    logic [ADDR_W-1:0]      pc_r;
    logic [PIN_COUNT-1:0]   output_r;
    logic [PIN_COUNT-1:0]   drive_r;
    logic [ADDR_W-1:0]      pc_next_s;
    logic [PIN_COUNT-1:0]   output_next_s;
    logic [PIN_COUNT-1:0]   drive_next_s;
    logic                   done_s;

    assign instr_s    = instr_t'(instr);
    assign field_hi_s = instr_s.args[7:5];
    assign field_lo_s = instr_s.args[4:0];

    // Decode and execute the current instruction into next-state values.
    always_comb begin
        pc_next_s     = pc_r + 5'd1;
        output_next_s = output_r;
        drive_next_s  = drive_r;
        done_s        = 1'b1;
        case (instr_s.opcode)
            OP_JMP: begin
                if (field_hi_s == COND_ALWAYS) begin
                    pc_next_s = field_lo_s;
                end else if ((field_hi_s == COND_PIN) && gpio_input[JMP_PIN]) begin
                    pc_next_s = field_lo_s;
                end else begin
                    pc_next_s = pc_r + 5'd1;
                end
            end
            OP_WAIT: begin
                if (gpio_input[field_lo_s] == instr_s.args[7]) begin
                    pc_next_s = pc_r + 5'd1;
                    done_s    = 1'b1;
                end else begin
                    pc_next_s = pc_r;
                    done_s    = 1'b0;
                end
            end
            OP_SET: begin
                case (field_hi_s)
                    DEST_PINS:    output_next_s = apply_set(output_r, SET_BASE_L, field_lo_s);
                    DEST_PINDIRS: drive_next_s  = apply_set(drive_r, SET_BASE_L, field_lo_s);
                    default:      output_next_s = output_r;
                endcase
            end
            default: pc_next_s = pc_r + 5'd1;
        endcase
    end

`ifdef PIO_DELAY_EN
    logic [DELAY_W-1:0] delay_r;

    // Sequencer state; a non-zero delay count idles the SM with pc and pins held.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= 5'd0;
            output_r <= 32'h0000_0000;
            drive_r  <= 32'h0000_0000;
            delay_r  <= 5'd0;
        end else if (enable) begin
            if (delay_r != 5'd0) begin
                delay_r <= delay_r - 5'd1;
            end else begin
                pc_r     <= pc_next_s;
                output_r <= output_next_s;
                drive_r  <= drive_next_s;
                delay_r  <= done_s ? instr_s.delay : 5'd0;
            end
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{instr_s.delay, done_s};

    // Sequencer state; every enabled cycle executes one instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= 5'd0;
            output_r <= 32'h0000_0000;
            drive_r  <= 32'h0000_0000;
        end else if (enable) begin
            pc_r     <= pc_next_s;
            output_r <= output_next_s;
            drive_r  <= drive_next_s;
        end
    end
`endif

    assign pc         = pc_r;
    assign fsm_output = output_r;
    assign fsm_drive  = drive_r;

endmodule

// File: rtl/pio_exec_unit.sv
// Programmable-I/O execution core: shared 32x16 program memory, NUM_SM sequencers
// and a per-pin priority arbiter. Build with PIO_DELAY_EN for per-instruction delays.
module pio_exec_unit
    import pio_pkg::*;
#(
    parameter int NUM_SM   = 4,
    parameter int SET_BASE = 0,
    parameter int JMP_PIN  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIN_COUNT-1:0] gpio_input,
    input  logic [NUM_SM-1:0]    sm_en,
    input  logic [INSTR_W-1:0]   data_in,
    input  logic [ADDR_W-1:0]    write_addr,
    input  logic                 write_en,
    output logic [PIN_COUNT-1:0] core_output,
    output logic [PIN_COUNT-1:0] core_drive
);

    logic [INSTR_W-1:0]   imem_r      [IMEM_DEPTH];
    logic [ADDR_W-1:0]    sm_pc_s     [NUM_SM];
    logic [INSTR_W-1:0]   sm_instr_s  [NUM_SM];
    logic [PIN_COUNT-1:0] sm_output_s [NUM_SM];
    logic [PIN_COUNT-1:0] sm_drive_s  [NUM_SM];

    // Program memory: cleared on reset, written by the loader port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < IMEM_DEPTH; a++) begin
                imem_r[a] <= 16'h0000;
            end
        end else if (write_en) begin
            imem_r[write_addr] <= data_in;
        end
    end

    for (genvar i = 0; i < NUM_SM; i++) begin : g_sm
        // A same-cycle write to this address is seen only from the next cycle.
        assign sm_instr_s[i] = imem_r[sm_pc_s[i]];

        pio_sm #(
            .SET_BASE (SET_BASE),
            .JMP_PIN  (JMP_PIN)
        ) u_sm (
            .clk        (clk),
            .rst        (rst),
            .enable     (sm_en[i]),
            .instr      (sm_instr_s[i]),
            .gpio_input (gpio_input),
            .pc         (sm_pc_s[i]),
            .fsm_output (sm_output_s[i]),
            .fsm_drive  (sm_drive_s[i])
        );
    end

    // Per-pin arbitration: the highest-numbered driving sequencer owns the pin value.
    always_comb begin
        core_output = 32'h0000_0000;
        core_drive  = 32'h0000_0000;
        for (int p = 0; p < PIN_COUNT; p++) begin
            for (int i = 0; i < NUM_SM; i++) begin
                if (sm_drive_s[i][p]) begin
                    core_drive[p]  = 1'b1;
                    core_output[p] = sm_output_s[i][p];
                end else begin
                    core_drive[p]  = core_drive[p];
                end
            end
        end
    end

    pio_exec_unit_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .core_output (core_output),
        .core_drive  (core_drive)
    );

endmodule

// File: tb/tb_pio_exec_unit.sv
// Directed, table-driven bench for pio_exec_unit (NUM_SM=4, SET_BASE=0, JMP_PIN=0).
module tb_pio_exec_unit;

    logic        clk;
    logic        rst;
    logic [31:0] gpio_input;
    logic [3:0]  sm_en;
    logic [15:0] data_in;
    logic [4:0]  write_addr;
    logic        write_en;
    logic [31:0] core_output;
    logic [31:0] core_drive;

    int total;
    int bad;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] gpio;
        logic [31:0] exp_out;
        logic [31:0] exp_drive;
        logic [4:0]  exp_pc;
    } vec_t;

    vec_t tbl [8];
    int   tbl_n;

    pio_exec_unit #(
        .NUM_SM   (4),
        .SET_BASE (0),
        .JMP_PIN  (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gpio_input  (gpio_input),
        .sm_en       (sm_en),
        .data_in     (data_in),
        .write_addr  (write_addr),
        .write_en    (write_en),
        .core_output (core_output),
        .core_drive  (core_drive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_pc0(input string name, input logic [4:0] exp);
        check(name, {27'd0, dut.sm_pc_s[0]}, {27'd0, exp});
    endtask

    task automatic load(input logic [4:0] a, input logic [15:0] d);
        write_en   = 1'b1;
        write_addr = a;
        data_in    = d;
        step();
        write_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        sm_en      = 4'h0;
        gpio_input = 32'h0;
        step();
        rst        = 1'b0;
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl_n; i++) begin
            sm_en      = tbl[i].en;
            gpio_input = tbl[i].gpio;
            step();
            check($sformatf("%s[%0d].out", name, i), core_output, tbl[i].exp_out);
            check($sformatf("%s[%0d].drive", name, i), core_drive, tbl[i].exp_drive);
            check_pc0($sformatf("%s[%0d].pc", name, i), tbl[i].exp_pc);
        end
        sm_en = 4'h0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        sm_en      = 4'h0;
        gpio_input = 32'h0;
        data_in    = 16'h0;
        write_addr = 5'd0;
        write_en   = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset.out", core_output, 32'h0);
        check("reset.drive", core_drive, 32'h0);
        check_pc0("reset.pc", 5'd0);

        // SET pindirs, SET pins, JMP-to-self on SM0; last row disabled.
        load(5'd0, 16'hE09F);
        load(5'd1, 16'hE015);
        load(5'd2, 16'h0002);
        tbl[0] = '{4'h1, 32'h0, 32'h00, 32'h1F, 5'd1};
        tbl[1] = '{4'h1, 32'h0, 32'h15, 32'h1F, 5'd2};
        tbl[2] = '{4'h1, 32'h0, 32'h15, 32'h1F, 5'd2};
        tbl[3] = '{4'h1, 32'h0, 32'h15, 32'h1F, 5'd2};
        tbl[4] = '{4'h0, 32'h0, 32'h15, 32'h1F, 5'd2};
        tbl_n  = 5;
        run_table("set");

        // Overwrite the word being executed: old word runs this cycle, new one next.
        sm_en      = 4'h1;
        write_en   = 1'b1;
        write_addr = 5'd2;
        data_in    = 16'hE01F;
        step();
        write_en = 1'b0;
        check("rw.old_out", core_output, 32'h15);
        check_pc0("rw.old_pc", 5'd2);
        step();
        check("rw.new_out", core_output, 32'h1F);
        check_pc0("rw.new_pc", 5'd3);

        // Reset mid-program clears state and program memory.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst.out", core_output, 32'h0);
        check("midrst.drive", core_drive, 32'h0);
        check_pc0("midrst.pc", 5'd0);
        step();
        step();
        step();
        check("midrst.imem_drive", core_drive, 32'h0);
        check_pc0("midrst.imem_pc", 5'd0);
        sm_en = 4'h0;

        // WAIT high on pin 3, then WAIT low on pin 3.
        load(5'd0, 16'h2083);
        load(5'd1, 16'h2003);
        load(5'd2, 16'h0002);
        sm_en      = 4'h1;
        gpio_input = 32'h0;
        for (int n = 0; n < 5; n++) begin
            step();
            check_pc0($sformatf("wait_hi_hold[%0d]", n), 5'd0);
        end
        gpio_input = 32'h8;
        step();
        check_pc0("wait_hi_go", 5'd1);
        step();
        check_pc0("wait_lo_hold", 5'd1);
        gpio_input = 32'h0;
        step();
        check_pc0("wait_lo_go", 5'd2);

        // Conditional JMP on pin 0, and a never-taken condition code.
        do_reset();
        load(5'd0, 16'h00C7);
        load(5'd1, 16'h0027);
        load(5'd2, 16'h0000);
        load(5'd7, 16'h0000);
        tbl[0] = '{4'h1, 32'h1, 32'h0, 32'h0, 5'd7};
        tbl[1] = '{4'h1, 32'h1, 32'h0, 32'h0, 5'd0};
        tbl[2] = '{4'h1, 32'h0, 32'h0, 32'h0, 5'd1};
        tbl[3] = '{4'h1, 32'h0, 32'h0, 32'h0, 5'd2};
        tbl[4] = '{4'h1, 32'h0, 32'h0, 32'h0, 5'd0};
        tbl_n  = 5;
        run_table("jmp");

        // Arbitration between SM0 and SM3 on pin 0.
        do_reset();
        load(5'd0, 16'hE081);
        load(5'd1, 16'hE001);
        load(5'd2, 16'hE080);
        load(5'd3, 16'h0003);
        tbl[0] = '{4'h9, 32'h0, 32'h0, 32'h1, 5'd1};
        tbl[1] = '{4'h1, 32'h0, 32'h0, 32'h1, 5'd2};
        tbl[2] = '{4'h8, 32'h0, 32'h1, 32'h1, 5'd2};
        tbl[3] = '{4'h1, 32'h0, 32'h1, 32'h1, 5'd3};
        tbl[4] = '{4'h8, 32'h0, 32'h0, 32'h0, 5'd3};
        tbl_n  = 5;
        run_table("arb");

        // NOP program with delay field 3: pc wrap, and delay handling per build.
        do_reset();
        for (int a = 0; a < 32; a++) begin
            load(5'(a), 16'h4300);
        end
        sm_en = 4'h1;
        for (int n = 1; n <= 70; n++) begin
            step();
`ifdef PIO_DELAY_EN
            check_pc0($sformatf("nop_pc[%0d]", n), 5'(((n + 3) / 4) % 32));
`else
            check_pc0($sformatf("nop_pc[%0d]", n), 5'(n % 32));
`endif
        end
        sm_en = 4'h0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
